// File: rtl/fpu_arb_pkg.sv
// Shared constants and helpers for the FPU request arbiter and its owner FIFO.
package fpu_arb_pkg;

    localparam int   FP32_W = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_owner_fifo.sv
// Owner-ID FIFO: records which requester issued each in-flight FPU operation.
// DEPTH must be a power of two >= 2; pointers carry an extra wrap bit.
module fpu_owner_fifo
    import fpu_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [clog2(DEPTH):0] count,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    // Head is read combinationally so the owner is known in the cycle the result arrives.
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one in-order FPU between NUM_REQ requesters,
// with an owner FIFO that steers each result back to its issuer.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int MAX_INFLIGHT  = 4,
    parameter int MIN_ISSUE_GAP = 0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            Req_Valid,
    output logic [NUM_REQ-1:0]            Req_Ready,
    input  logic [FP32_W*NUM_REQ-1:0]     Req_Data1,
    input  logic [FP32_W*NUM_REQ-1:0]     Req_Data2,
    input  logic [NUM_REQ-1:0]            Req_Op,
    output logic [NUM_REQ-1:0]            Rsp_Valid,
    output logic [FP32_W-1:0]             Rsp_Data,
    output logic [FP32_W-1:0]             Fpu_Data1,
    output logic [FP32_W-1:0]             Fpu_Data2,
    output logic                          Fpu_Op,
    output logic                          Fpu_In_Data_Valid,
    input  logic [FP32_W-1:0]             Fpu_Data_Out,
    input  logic                          Fpu_Out_Data_Valid,
    output logic [clog2(MAX_INFLIGHT):0]  Inflight,
    output logic                          Err_Spurious
);

    localparam int OWN_W = clog2(NUM_REQ);
    localparam int GAP_W = clog2(MIN_ISSUE_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_ISSUE_GAP);
    localparam logic [OWN_W-1:0] RR_INIT  = OWN_W'(NUM_REQ - 1);

    logic [FP32_W-1:0] req_d1 [NUM_REQ];
    logic [FP32_W-1:0] req_d2 [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_d1[gi] = Req_Data1[gi*FP32_W +: FP32_W];
            assign req_d2[gi] = Req_Data2[gi*FP32_W +: FP32_W];
        end
    endgenerate

    logic [OWN_W-1:0]  rr_q,       rr_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic [FP32_W-1:0] fpu_d1_q,   fpu_d1_d;
    logic [FP32_W-1:0] fpu_d2_q,   fpu_d2_d;
    logic              fpu_op_q,   fpu_op_d;
    logic              fpu_vld_q,  fpu_vld_d;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [FP32_W-1:0] rsp_data_q, rsp_data_d;
    logic              err_q,      err_d;

    logic [NUM_REQ-1:0] grant;
    logic [OWN_W-1:0]   grant_idx;
    logic               grant_any;
    logic               can_issue;
    logic               accept;
    logic               ret_pop;
    logic [OWN_W-1:0]   fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin : rr_search
        logic [OWN_W:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (OWN_W+1)'(k);
            if (cand >= (OWN_W+1)'(NUM_REQ)) begin
                cand = cand - (OWN_W+1)'(NUM_REQ);
            end
            if (!grant_any && Req_Valid[cand[OWN_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[OWN_W-1:0];
            end
        end
        if (grant_any) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

    // Credit check uses the registered occupancy only; a same-cycle return does not free a slot.
    assign can_issue = !fifo_full && (gap_q == '0);
    assign Req_Ready = (can_issue && !Reset) ? grant : '0;
    assign accept    = grant_any && can_issue && !Reset;
    assign ret_pop   = Fpu_Out_Data_Valid && !fifo_empty;

    always_comb begin
        rr_d       = rr_q;
        gap_d      = gap_q;
        fpu_d1_d   = fpu_d1_q;
        fpu_d2_d   = fpu_d2_q;
        fpu_op_d   = fpu_op_q;
        fpu_vld_d  = 1'b0;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;

        if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        if (accept) begin
            rr_d      = grant_idx;
            gap_d     = GAP_LOAD;
            fpu_d1_d  = req_d1[grant_idx];
            fpu_d2_d  = req_d2[grant_idx];
            fpu_op_d  = (Req_Op[grant_idx] == OP_MUL) ? OP_MUL : OP_ADD;
            fpu_vld_d = 1'b1;
        end

        if (ret_pop) begin
            rsp_data_d = Fpu_Data_Out;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_vld_d[i] = (fifo_dout == OWN_W'(i));
            end
        end else if (Fpu_Out_Data_Valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_q       <= RR_INIT;
            gap_q      <= '0;
            fpu_d1_q   <= '0;
            fpu_d2_q   <= '0;
            fpu_op_q   <= 1'b0;
            fpu_vld_q  <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            gap_q      <= gap_d;
            fpu_d1_q   <= fpu_d1_d;
            fpu_d2_q   <= fpu_d2_d;
            fpu_op_q   <= fpu_op_d;
            fpu_vld_q  <= fpu_vld_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    fpu_owner_fifo #(
        .WIDTH (OWN_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_owner_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (accept),
        .pop   (ret_pop),
        .din   (grant_idx),
        .dout  (fifo_dout),
        .count (Inflight),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign Fpu_Data1         = fpu_d1_q;
    assign Fpu_Data2         = fpu_d2_q;
    assign Fpu_Op            = fpu_op_q;
    assign Fpu_In_Data_Valid = fpu_vld_q;
    assign Rsp_Valid         = rsp_vld_q;
    assign Rsp_Data          = rsp_data_q;
    assign Err_Spurious      = err_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Scoreboard bench for fpu_req_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares issues, responses and directed checks.
module tb_fpu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid, req_ready, req_op, rsp_valid;
    logic [63:0] req_d1, req_d2;
    logic [31:0] rsp_data, fpu_d1, fpu_d2, fout_data;
    logic        fpu_op, fpu_vld, fout_valid, err;
    logic [2:0]  inflight;

    logic [1:0]  g_req_valid, g_req_ready, g_req_op, g_rsp_valid;
    logic [63:0] g_req_d1, g_req_d2;
    logic [31:0] g_rsp_data, g_fpu_d1, g_fpu_d2, g_fout_data;
    logic        g_fpu_op, g_fpu_vld, g_fout_valid, g_err;
    logic [2:0]  g_inflight;

    fpu_req_arbiter #(.NUM_REQ(2), .MAX_INFLIGHT(4), .MIN_ISSUE_GAP(0)) dut (
        .Clock(clk), .Reset(rst),
        .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Req_Data1(req_d1), .Req_Data2(req_d2), .Req_Op(req_op),
        .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data),
        .Fpu_Data1(fpu_d1), .Fpu_Data2(fpu_d2), .Fpu_Op(fpu_op),
        .Fpu_In_Data_Valid(fpu_vld),
        .Fpu_Data_Out(fout_data), .Fpu_Out_Data_Valid(fout_valid),
        .Inflight(inflight), .Err_Spurious(err)
    );

    fpu_req_arbiter #(.NUM_REQ(2), .MAX_INFLIGHT(4), .MIN_ISSUE_GAP(2)) dut_gap (
        .Clock(clk), .Reset(rst),
        .Req_Valid(g_req_valid), .Req_Ready(g_req_ready),
        .Req_Data1(g_req_d1), .Req_Data2(g_req_d2), .Req_Op(g_req_op),
        .Rsp_Valid(g_rsp_valid), .Rsp_Data(g_rsp_data),
        .Fpu_Data1(g_fpu_d1), .Fpu_Data2(g_fpu_d2), .Fpu_Op(g_fpu_op),
        .Fpu_In_Data_Valid(g_fpu_vld),
        .Fpu_Data_Out(g_fout_data), .Fpu_Out_Data_Valid(g_fout_valid),
        .Inflight(g_inflight), .Err_Spurious(g_err)
    );

    // Scoreboard queues
    logic [64:0]  iss_q[$];     // {data1, data2, op}
    logic [33:0]  rsp_q[$];     // {owner one-hot, data}
    string        chk_name[$];
    logic [127:0] chk_act[$];
    logic [127:0] chk_exp[$];
    int           stub_due[$];
    logic [31:0]  stub_res[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit stub_en = 1'b0;

    // Monitor: sole owner of the comparison counters.
    always @(negedge clk) begin
        string        nm;
        logic [127:0] a, e;
        logic [64:0]  ie;
        logic [33:0]  re;
        while (chk_name.size() > 0) begin
            nm = chk_name.pop_front();
            a  = chk_act.pop_front();
            e  = chk_exp.pop_front();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %0h, required %0h", nm, a, e);
            end
        end
        if (fpu_vld === 1'b1) begin
            n_vec++;
            if (iss_q.size() == 0) begin
                n_bad++;
                $display("FAIL issue_unexpected: got d1=%h d2=%h op=%b, required no issue", fpu_d1, fpu_d2, fpu_op);
            end else begin
                ie = iss_q.pop_front();
                if ({fpu_d1, fpu_d2, fpu_op} !== ie) begin
                    n_bad++;
                    $display("FAIL issue_data: got %h/%h/%b, required %h/%h/%b",
                             fpu_d1, fpu_d2, fpu_op, ie[64:33], ie[32:1], ie[0]);
                end
            end
            if (stub_en) begin
                stub_due.push_back(cyc + 2);
                stub_res.push_back(fpu_d1 ^ fpu_d2);
            end
        end
        if (rsp_valid !== 2'b00) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h, required no response", rsp_valid, rsp_data);
            end else begin
                re = rsp_q.pop_front();
                if ({rsp_valid, rsp_data} !== re) begin
                    n_bad++;
                    $display("FAIL rsp_data: got valid=%b data=%h, required valid=%b data=%h",
                             rsp_valid, rsp_data, re[33:32], re[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fout_valid = 1'b0;
        if (stub_en && stub_due.size() > 0 && stub_due[0] <= cyc) begin
            fout_valid = 1'b1;
            fout_data  = stub_res[0];
            stub_due.delete(0);
            stub_res.delete(0);
        end
    endtask

    task automatic look();
        #2;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk_name.push_back(nm);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic expect_issue(input logic [31:0] d1, input logic [31:0] d2, input logic op);
        iss_q.push_back({d1, d2, op});
    endtask

    task automatic expect_rsp(input logic [1:0] oh, input logic [31:0] data);
        rsp_q.push_back({oh, data});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_op = '0; req_d1 = '0; req_d2 = '0;
        fout_valid = 1'b0; fout_data = '0;
        g_req_valid = '0; g_req_op = '0; g_req_d1 = '0; g_req_d2 = '0;
        g_fout_valid = 1'b0; g_fout_data = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_data, fpu_d1, fpu_d2, fpu_vld, fpu_op, inflight, err}, '0);
        chk("reset_outputs_gap", {g_req_ready, g_rsp_valid, g_rsp_data, g_fpu_d1, g_fpu_vld, g_fpu_op, g_inflight, g_err}, '0);
        chk("reset_outputs_gap_d2", g_fpu_d2, '0);
        step();
        step();
        rst = 1'b0;

        // Single add request from requester 0
        step();
        req_valid = 2'b01; req_d1[31:0] = 32'h3F8CCCCD; req_d2[31:0] = 32'h400CCCCD; req_op = 2'b00;
        look();
        chk("t1_ready", req_ready, 2'b01);
        expect_issue(32'h3F8CCCCD, 32'h400CCCCD, 1'b0);
        step();
        req_valid = 2'b00;
        look();
        chk("t1_issue_pulse", fpu_vld, 1);
        step();
        fout_valid = 1'b1; fout_data = 32'h40533334;
        expect_rsp(2'b01, 32'h40533334);
        look();
        chk("t1_issue_single", fpu_vld, 0);
        chk("t1_no_early_rsp", rsp_valid, 0);
        step();
        look();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_inflight_zero", inflight, 0);
        step();

        // Contention with stub returning three cycles after acceptance
        do_reset();
        stub_en = 1'b1;
        req_valid = 2'b11; req_op = 2'b10;
        req_d1 = {32'h22222222, 32'h11111111};
        req_d2 = {32'h02020202, 32'h01010101};
        for (int k = 0; k < 12; k++) begin
            look();
            chk("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_inflight", inflight, (k < 3) ? k : 3);
            if (k % 2 == 0) begin
                expect_issue(32'h11111111, 32'h01010101, 1'b0);
                expect_rsp(2'b01, 32'h10101010);
            end else begin
                expect_issue(32'h22222222, 32'h02020202, 1'b1);
                expect_rsp(2'b10, 32'h20202020);
            end
            step();
        end
        req_valid = 2'b00;
        repeat (6) step();
        look();
        chk("t2_drained", inflight, 0);
        stub_en = 1'b0;
        step();

        // Credit stall: results withheld until four ops are in flight
        do_reset();
        req_valid = 2'b01; req_op = 2'b00;
        req_d1[31:0] = 32'h41200000; req_d2[31:0] = 32'h40A00000;
        for (int k = 0; k < 4; k++) begin
            look();
            chk("t3_ready", req_ready, 2'b01);
            expect_issue(32'h41200000, 32'h40A00000, 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            look();
            chk("t3_stall_ready", req_ready, 2'b00);
            chk("t3_full", inflight, 4);
            step();
        end
        fout_valid = 1'b1; fout_data = 32'hC0DE0001;
        expect_rsp(2'b01, 32'hC0DE0001);
        look();
        chk("t3_no_bypass", req_ready, 2'b00);
        step();
        look();
        chk("t3_one_credit", req_ready, 2'b01);
        chk("t3_inflight_3", inflight, 3);
        expect_issue(32'h41200000, 32'h40A00000, 1'b0);
        step();
        look();
        chk("t3_stall_again", req_ready, 2'b00);
        chk("t3_full_again", inflight, 4);
        step();
        req_valid = 2'b00;
        for (int r = 0; r < 4; r++) begin
            fout_valid = 1'b1; fout_data = 32'hC0DE0010 + 32'(r);
            expect_rsp(2'b01, 32'hC0DE0010 + 32'(r));
            step();
        end
        step();
        look();
        chk("t3_drained", inflight, 0);
        step();

        // Minimum issue gap of 2 on the second instance
        do_reset();
        g_req_valid = 2'b10;
        g_req_d1 = {32'h40400000, 32'h0};
        g_req_d2 = {32'h40800000, 32'h0};
        for (int k = 0; k < 12; k++) begin
            look();
            chk("t4_gap_ready", g_req_ready, (k % 3 == 0) ? 2'b10 : 2'b00);
            chk("t4_gap_issue", g_fpu_vld, (k % 3 == 1) ? 1 : 0);
            step();
        end
        g_req_valid = 2'b00;

        // Asynchronous reset with two ops in flight, then a late result
        do_reset();
        req_valid = 2'b01; req_d1[31:0] = 32'h3F800000; req_d2[31:0] = 32'h40000000;
        look();
        chk("t5_ready_a", req_ready, 2'b01);
        expect_issue(32'h3F800000, 32'h40000000, 1'b0);
        step();
        look();
        chk("t5_ready_b", req_ready, 2'b01);
        expect_issue(32'h3F800000, 32'h40000000, 1'b0);
        step();
        req_valid = 2'b00;
        look();
        step();
        look();
        chk("t5_inflight_before", inflight, 2);
        chk("t5_fpu_d1_before", fpu_d1, 32'h3F800000);
        rst = 1'b1;
        #1;
        chk("t5_async_clear", {fpu_vld, fpu_op, fpu_d1, fpu_d2, rsp_valid, req_ready, inflight, err}, '0);
        step();
        rst = 1'b0;
        fout_valid = 1'b1; fout_data = 32'hDEADBEEF;
        look();
        chk("t5_err_before", err, 0);
        step();
        look();
        chk("t5_err_set", err, 1);
        chk("t5_no_rsp", rsp_valid, 2'b00);
        step();

        // Multiply from requester 1
        req_valid = 2'b10; req_op = 2'b10;
        req_d1[63:32] = 32'h3F8CCCCD; req_d2[63:32] = 32'hC00CCCCD;
        look();
        chk("t6_ready", req_ready, 2'b10);
        expect_issue(32'h3F8CCCCD, 32'hC00CCCCD, 1'b1);
        step();
        req_valid = 2'b00;
        look();
        chk("t6_fpu_op", fpu_op, 1);
        step();
        fout_valid = 1'b1; fout_data = 32'hC01AE148;
        expect_rsp(2'b10, 32'hC01AE148);
        step();
        look();
        chk("t6_rsp_owner", rsp_valid, 2'b10);
        chk("t6_rsp_data", rsp_data, 32'hC01AE148);
        chk("t6_err_sticky", err, 1);
        step();
        look();
        chk("t6_inflight_zero", inflight, 0);

        chk("iss_leftover", iss_q.size(), 0);
        chk("rsp_leftover", rsp_q.size(), 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
